wb_timer: RTL and testbench
===========================

# wb_timer

Memory-mapped 64-bit machine timer on the Wishbone pipelined slave side of the core-to-Wishbone bridge.
- Accepts single-beat reads and writes issued by the data-port bridge.
- Provides a RISC-V style mtime/mtimecmp pair with a programmable prescaler.
- Drives the core's timer interrupt line.

## Interface
Parameters:
- PRESCALE_W, 16, width of the prescale register and counter.
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp; the default keeps the interrupt low out of reset.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- wb_cyc  in  1  bus cycle in progress.
- wb_stb  in  1  request strobe.
- wb_we  in  1  1 = write.
- wb_adr  in  32  byte address; only adr[4:2] is decoded, upper bits are decoded by the interconnect.
- wb_sel  in  4  byte enables.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid only while wb_ack = 1, otherwise 0.
- wb_ack  out  1  transfer completed.
- wb_err  out  1  unmapped offset.
- wb_stall  out  1  tied to 0; every request is accepted in its cycle.
- timer_irq  out  1  registered interrupt, level-sensitive.

## Operation
Register map (word offsets):
- 0x00 MTIME_LO.
- 0x04 MTIME_HI.
- 0x08 MTIMECMP_LO.
- 0x0C MTIMECMP_HI.
- 0x10 PRESCALE, bits [PRESCALE_W-1:0]; upper bits read 0.
- 0x14–0x1C: unmapped.

Bus accesses:
- A request is accepted when wb_cyc & wb_stb.
- Writes honor wb_sel per byte.
- Reads ignore wb_sel.
- An unmapped offset completes with wb_err instead of wb_ack and has no side effects.

Prescaler and time base:
- pre_cnt counts 0..PRESCALE.
- tick = (pre_cnt == PRESCALE); on tick, pre_cnt returns to 0 and mtime increments by 1.
- PRESCALE = 0 gives one increment every clk.
- mtime is a 64-bit counter that wraps from all-ones to 0 with no flag.
- Writing PRESCALE clears pre_cnt in the same cycle.

Atomic 64-bit read:
- A read of MTIME_LO latches mtime[63:32] into hi_shadow.
- A read of MTIME_HI returns hi_shadow, not live mtime.
- A write to either MTIME half does not update hi_shadow.

Interrupt:
- timer_irq <= (mtime >= mtimecmp), unsigned 64-bit compare, registered.
- It stays high until mtimecmp is raised or mtime is written lower.

Simultaneous events:
- A bus write to a MTIME half in the same cycle as a tick: the written bytes take the written value; the untouched half keeps its pre-tick value, with no carry applied from the lost increment.
- A MTIME_LO write does not propagate a carry into MTIME_HI.

## Timing
- Reset values: wb_ack = 0, wb_err = 0, wb_dat_o = 0, timer_irq = 0, mtime = 0, hi_shadow = 0, pre_cnt = 0, PRESCALE = 0, mtimecmp = CMP_RESET.
- Latency: wb_ack or wb_err is asserted exactly 1 cycle after acceptance, for 1 cycle.
- Back-to-back requests on consecutive cycles produce acks on consecutive cycles, in order.
- Read data is sampled in the acceptance cycle and presented, registered, with the ack.
- Write side effects are visible to a read accepted in the following cycle.
- timer_irq reflects a compare-relevant write 2 cycles after acceptance: register update, then compare register.
- If wb_cyc is low in the cycle where the ack would be driven, the ack/err is suppressed (abort). Register side effects already taken are not undone.
- Reset asserted mid-transfer drops ack, err and irq immediately; no ack is emitted after reset release.

## Structure
- Package wb_timer_pkg holds:
  - the register offset enum (REG_MTIME_LO … REG_PRESCALE);
  - the 3-bit offset type;
  - the CMP_RESET default constant.
- One sub-module, wb_timer_prescaler: PRESCALE_W-bit counter with compare value, synchronous clear input, and tick output.
- The top level contains bus decode, the register file, hi_shadow, mtime, the compare and the ack pipeline.

## Test plan
- Reset, then idle 10 cycles with PRESCALE = 0: read MTIME_LO returns about 10 (exact cycle count checked by the model); timer_irq = 0.
- Write PRESCALE = 3, then sample MTIME_LO twice 40 cycles apart: the difference equals 10.
- Write mtime = 0x0000_0000_FFFF_FFFE with PRESCALE = 0, wait 3 cycles, read LO then HI:
  - HI = 1, LO matches the model;
  - a second HI read without a new LO read returns the latched value.
- Write mtimecmp = 20 with mtime counting from 0: timer_irq rises at the first cycle where mtime ≥ 20 (+1 register); writing MTIMECMP_HI = 1 lowers it 2 cycles later.
- Four back-to-back pipelined reads (offsets 0x0, 0x8, 0x14, 0x10): responses are ack, ack, err, ack on 4 consecutive cycles, and wb_stall stays 0.
- Partial write to MTIMECMP_LO with sel = 4'b0010, data 0xAABBCCDD, over 0xFFFFFFFF: readback is 0xFFFFCCFF.

Source files
------------

// File: rtl/wb_timer_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wb_timer_pkg
// Shared definitions for the Wishbone machine timer:
//   - reg_off_t  : 3-bit word offset taken from wb_adr[4:2]
//   - reg_off_e  : named register offsets of the timer register map
//   - CMP_RESET_DEFAULT : mtimecmp reset value that keeps the interrupt low
//   - merge_bytes : byte-enable merge used by every writable register
// -----------------------------------------------------------------------------
package wb_timer_pkg;

  typedef logic [2:0] reg_off_t;

  typedef enum logic [2:0] {
    REG_MTIME_LO    = 3'd0,
    REG_MTIME_HI    = 3'd1,
    REG_MTIMECMP_LO = 3'd2,
    REG_MTIMECMP_HI = 3'd3,
    REG_PRESCALE    = 3'd4
  } reg_off_e;

  localparam logic [63:0] CMP_RESET_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace only the bytes whose enable is set, keep the rest of the old word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Offsets above PRESCALE fall into the unmapped hole and answer with wb_err.
  function automatic logic is_mapped(input reg_off_t off);
    return off <= reg_off_t'(REG_PRESCALE);
  endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wb_timer_prescaler
// Divides clk down to the mtime increment rate. The counter runs 0..prescale
// and emits a one-cycle tick when it sits on the compare value.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   clear       : synchronous restart of the count at 0 (prescale rewrite)
//   prescale    : compare value; 0 ticks every cycle
//   tick        : combinational, high in the cycle the count equals prescale
// -----------------------------------------------------------------------------
module wb_timer_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt_q;
  logic [PRESCALE_W-1:0] pre_cnt_d;

  // The tick is taken from the current count and the current compare value,
  // so a prescale rewrite still lets an in-flight tick through while the
  // count itself restarts at 0.
  always_comb begin
    tick      = (pre_cnt_q == prescale);
    pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    if (clear || tick) begin
      pre_cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/wb_timer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wb_timer
// RISC-V style 64-bit machine timer (mtime / mtimecmp) with a programmable
// prescaler, behind a single-beat Wishbone pipelined slave port.
// Ports:
//   clk, rst_n         : clock and asynchronous active-low reset
//   wb_cyc, wb_stb     : request qualifiers; a request is taken when both high
//   wb_we              : 1 = write
//   wb_adr             : byte address, only [4:2] decoded
//   wb_sel             : byte enables for writes
//   wb_dat_i           : write data
//   wb_dat_o           : registered read data, 0 unless wb_ack is high
//   wb_ack / wb_err    : one-cycle response, one cycle after acceptance
//   wb_stall           : always 0, every request accepted in its cycle
//   timer_irq          : registered level interrupt, mtime >= mtimecmp
// Register map (word offsets): 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO,
// 3 MTIMECMP_HI, 4 PRESCALE, 5..7 unmapped.
// -----------------------------------------------------------------------------
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 16,
  parameter logic [63:0] CMP_RESET  = CMP_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        wb_stall,
  output logic        timer_irq
);

  // Register state.
  logic [63:0]           mtime_q,     mtime_d;
  logic [63:0]           mtimecmp_q,  mtimecmp_d;
  logic [PRESCALE_W-1:0] prescale_q,  prescale_d;
  logic [31:0]           hi_shadow_q, hi_shadow_d;

  // Response pipeline and interrupt.
  logic                  ack_q,  ack_d;
  logic                  err_q,  err_d;
  logic [31:0]           dat_q,  dat_d;
  logic                  irq_q,  irq_d;

  // Decode.
  reg_off_t              off;
  logic                  req;
  logic                  mapped;
  logic                  wr_en;
  logic                  rd_en;
  logic [31:0]           rdata;
  logic                  tick;
  logic                  pre_clear;
  logic                  resp_live;
  logic                  unused_adr;

  // Only the word offset inside the timer window matters; the interconnect
  // has already matched the upper bits.
  assign unused_adr = ^{wb_adr[31:5], wb_adr[1:0]};

  // Request decode: every request is accepted in its cycle, so the only
  // decision is whether the offset hits a register or the unmapped hole.
  always_comb begin
    off    = wb_adr[4:2];
    req    = wb_cyc & wb_stb;
    mapped = is_mapped(off);
    wr_en  = req &  wb_we & mapped;
    rd_en  = req & ~wb_we & mapped;
  end

  wb_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (pre_clear),
    .prescale (prescale_q),
    .tick     (tick)
  );

  // Register file next-state. A write to one mtime half replaces that half
  // from the pre-tick value and leaves the other half at its pre-tick value:
  // the increment of a colliding tick is dropped rather than carried.
  // A MTIME_LO read snapshots the upper half so a following MTIME_HI read
  // gives a consistent 64-bit value even if the low half wrapped meanwhile.
  always_comb begin
    mtime_d     = mtime_q + 64'(tick);
    mtimecmp_d  = mtimecmp_q;
    prescale_d  = prescale_q;
    hi_shadow_d = hi_shadow_q;
    pre_clear   = 1'b0;

    if (wr_en) begin
      case (off)
        REG_MTIME_LO: begin
          mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wb_dat_i, wb_sel)};
        end
        REG_MTIME_HI: begin
          mtime_d = {merge_bytes(mtime_q[63:32], wb_dat_i, wb_sel), mtime_q[31:0]};
        end
        REG_MTIMECMP_LO: begin
          mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], wb_dat_i, wb_sel);
        end
        REG_MTIMECMP_HI: begin
          mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wb_dat_i, wb_sel);
        end
        REG_PRESCALE: begin
          prescale_d = PRESCALE_W'(merge_bytes(32'(prescale_q), wb_dat_i, wb_sel));
          pre_clear  = 1'b1;
        end
        default: begin
        end
      endcase
    end

    if (rd_en && (off == reg_off_t'(REG_MTIME_LO))) begin
      hi_shadow_d = mtime_q[63:32];
    end
  end

  // Read multiplexer, sampled in the acceptance cycle. PRESCALE_W is
  // assumed to be at most 32 so the prescale value zero-extends.
  always_comb begin
    rdata = '0;
    case (off)
      REG_MTIME_LO:    rdata = mtime_q[31:0];
      REG_MTIME_HI:    rdata = hi_shadow_q;
      REG_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
      REG_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
      REG_PRESCALE:    rdata = 32'(prescale_q);
      default:         rdata = '0;
    endcase
  end

  // Response and interrupt next-state. Unmapped offsets produce err and no
  // data; the interrupt is a registered compare of the current registers.
  always_comb begin
    ack_d = req &  mapped;
    err_d = req & ~mapped;
    dat_d = rd_en ? rdata : '0;
    irq_d = (mtime_q >= mtimecmp_q);
  end

  // All state flops share the asynchronous reset so a reset in the middle
  // of a transfer drops ack, err and the interrupt at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q     <= '0;
      mtimecmp_q  <= CMP_RESET;
      prescale_q  <= '0;
      hi_shadow_q <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      dat_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      prescale_q  <= prescale_d;
      hi_shadow_q <= hi_shadow_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      dat_q       <= dat_d;
      irq_q       <= irq_d;
    end
  end

  // A master that drops wb_cyc before the response aborts it; the response
  // is masked but register side effects already taken stay in place.
  always_comb begin
    resp_live = wb_cyc;
    wb_ack    = ack_q & resp_live;
    wb_err    = err_q & resp_live;
    wb_dat_o  = (ack_q & resp_live) ? dat_q : '0;
    wb_stall  = 1'b0;
    timer_irq = irq_q;
  end

endmodule

// File: tb/tb_wb_timer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_wb_timer
// Scoreboard bench for wb_timer. A reference model, driven by the bench's own
// bus requests, describes mtime arithmetically from an anchor point
// (value, cycle, prescale phase) instead of stepping a counter. Each accepted
// request pushes its expected response, tagged with the cycle it is due in;
// a negedge monitor pops and compares, and also checks timer_irq every cycle.
// -----------------------------------------------------------------------------
module tb_wb_timer;

  localparam int unsigned PRESCALE_W = 16;
  localparam longint unsigned PRE_MASK = (64'd1 << PRESCALE_W) - 1;

  logic        clk;
  logic        rst_n;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_stall;
  logic        timer_irq;

  wb_timer #(
    .PRESCALE_W (PRESCALE_W),
    .CMP_RESET  (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_adr    (wb_adr),
    .wb_sel    (wb_sel),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err),
    .wb_stall  (wb_stall),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected response for one accepted request.
  typedef struct {
    longint unsigned due;
    bit              is_err;
    bit              is_read;
    logic [31:0]     data;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state.
  longint unsigned cyc_cnt  = 0;
  longint unsigned a_val    = 0;
  longint unsigned a_cyc    = 0;
  longint unsigned a_pre    = 0;
  longint unsigned m_pre    = 0;
  longint unsigned m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
  logic [31:0]     m_shadow = '0;
  logic            exp_irq  = 1'b0;

  longint unsigned mdl_cur;
  longint unsigned mdl_new;
  logic [2:0]      mdl_off;
  exp_t            mdl_e;
  exp_t            mon_e;

  // mtime after n clock edges counted from the anchor: one increment every
  // (PRESCALE+1) cycles, phase-shifted by the prescale count at the anchor.
  function automatic longint unsigned mtime_at(input longint unsigned n);
    return a_val + (a_pre + (n - a_cyc)) / (m_pre + 1);
  endfunction

  function automatic longint unsigned phase_at(input longint unsigned n);
    return (a_pre + (n - a_cyc)) % (m_pre + 1);
  endfunction

  function automatic logic [31:0] tb_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc_cnt);
    end
  endtask

  // Model: at each edge, take the request the bench is presenting and
  // compute its response and register effects from the current model state.
  always @(posedge clk) begin
    if (!rst_n) begin
      a_val    = 0;
      a_cyc    = cyc_cnt + 1;
      a_pre    = 0;
      m_pre    = 0;
      m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
      m_shadow = '0;
      exp_irq  = 1'b0;
      exp_q.delete();
    end else begin
      mdl_cur = mtime_at(cyc_cnt);
      exp_irq = (mdl_cur >= m_cmp);
      if (wb_cyc && wb_stb) begin
        mdl_off       = wb_adr[4:2];
        mdl_e.due     = cyc_cnt + 1;
        mdl_e.is_err  = (mdl_off > 3'd4);
        mdl_e.is_read = !wb_we;
        mdl_e.data    = '0;
        if (!mdl_e.is_err && !wb_we) begin
          case (mdl_off)
            3'd0: begin mdl_e.data = mdl_cur[31:0]; m_shadow = mdl_cur[63:32]; end
            3'd1: mdl_e.data = m_shadow;
            3'd2: mdl_e.data = m_cmp[31:0];
            3'd3: mdl_e.data = m_cmp[63:32];
            default: mdl_e.data = 32'(m_pre);
          endcase
        end else if (!mdl_e.is_err) begin
          case (mdl_off)
            3'd0: begin
              mdl_new = {mdl_cur[63:32], tb_merge(mdl_cur[31:0], wb_dat_i, wb_sel)};
              a_pre   = phase_at(cyc_cnt + 1);
              a_val   = mdl_new;
              a_cyc   = cyc_cnt + 1;
            end
            3'd1: begin
              mdl_new = {tb_merge(mdl_cur[63:32], wb_dat_i, wb_sel), mdl_cur[31:0]};
              a_pre   = phase_at(cyc_cnt + 1);
              a_val   = mdl_new;
              a_cyc   = cyc_cnt + 1;
            end
            3'd2: m_cmp[31:0]  = tb_merge(m_cmp[31:0], wb_dat_i, wb_sel);
            3'd3: m_cmp[63:32] = tb_merge(m_cmp[63:32], wb_dat_i, wb_sel);
            default: begin
              mdl_new = mtime_at(cyc_cnt + 1);
              a_val   = mdl_new;
              a_cyc   = cyc_cnt + 1;
              a_pre   = 0;
              m_pre   = longint'(tb_merge(32'(m_pre), wb_dat_i, wb_sel)) & PRE_MASK;
            end
          endcase
        end
        exp_q.push_back(mdl_e);
      end
    end
    cyc_cnt = cyc_cnt + 1;
  end

  // Monitor: compare the interrupt every cycle and the bus response in the
  // cycle it is due. A due response with wb_cyc low is an abort and must
  // not appear on the bus.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("irq", 64'(timer_irq), 64'(exp_irq));
      if (exp_q.size() > 0 && exp_q[0].due == cyc_cnt) begin
        mon_e = exp_q.pop_front();
        checkOutput("stall", 64'(wb_stall), 64'd0);
        if (!wb_cyc) begin
          checkOutput("abort_ack", 64'(wb_ack), 64'd0);
          checkOutput("abort_err", 64'(wb_err), 64'd0);
        end else if (mon_e.is_err) begin
          checkOutput("err", 64'(wb_err), 64'd1);
          checkOutput("err_no_ack", 64'(wb_ack), 64'd0);
        end else begin
          checkOutput("ack", 64'(wb_ack), 64'd1);
          checkOutput("ack_no_err", 64'(wb_err), 64'd0);
          if (mon_e.is_read) checkOutput("rdata", 64'(wb_dat_o), 64'(mon_e.data));
        end
      end else if (wb_ack || wb_err) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL spurious_resp: got ack=%0b err=%0b, expected none (cycle %0d)",
                 wb_ack, wb_err, cyc_cnt);
      end else begin
        checkOutput("dat_idle", 64'(wb_dat_o), 64'd0);
      end
    end
  end

  // One request cycle; the bench is always at 1 time unit after an edge
  // when this is entered and when it returns.
  task automatic applyStimulus(input bit we, input logic [2:0] off,
                               input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] junk;
    junk     = $urandom;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = we;
    wb_adr   = {junk[31:5], off, junk[1:0]};
    wb_sel   = sel;
    wb_dat_i = dat;
    @(posedge clk);
    #1;
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hard stop in case the bench itself stalls.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  r_off;
    logic [3:0]  r_sel;
    logic [31:0] r_dat;
    bit          r_we;

    rst_n    = 1'b0;
    wb_cyc   = 1'b0;
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
    wb_adr   = '0;
    wb_sel   = '0;
    wb_dat_i = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ack", 64'(wb_ack), 64'd0);
    checkOutput("rst_err", 64'(wb_err), 64'd0);
    checkOutput("rst_dat", 64'(wb_dat_o), 64'd0);
    checkOutput("rst_irq", 64'(timer_irq), 64'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    wb_cyc = 1'b1;
    $display("[TB] reset released");

    // Free-running count at PRESCALE = 0.
    idleCycles(10);
    applyStimulus(1'b0, 3'd0, 4'hF, 32'h0);

    // PRESCALE = 3: two samples 40 cycles apart differ by 10.
    applyStimulus(1'b1, 3'd4, 4'hF, 32'd3);
    applyStimulus(1'b0, 3'd0, 4'hF, 32'h0);
    idleCycles(39);
    applyStimulus(1'b0, 3'd0, 4'hF, 32'h0);
    applyStimulus(1'b0, 3'd4, 4'hF, 32'h0);

    // Carry into the upper half and the latched high word.
    applyStimulus(1'b1, 3'd4, 4'hF, 32'd0);
    applyStimulus(1'b1, 3'd0, 4'hF, 32'hFFFF_FFFE);
    applyStimulus(1'b1, 3'd1, 4'hF, 32'h0);
    idleCycles(3);
    applyStimulus(1'b0, 3'd0, 4'hF, 32'h0);
    applyStimulus(1'b0, 3'd1, 4'hF, 32'h0);
    idleCycles(2);
    applyStimulus(1'b0, 3'd1, 4'hF, 32'h0);

    // Interrupt rise at mtime >= 20, fall after raising the compare value.
    applyStimulus(1'b1, 3'd0, 4'hF, 32'h0);
    applyStimulus(1'b1, 3'd1, 4'hF, 32'h0);
    applyStimulus(1'b1, 3'd2, 4'hF, 32'd20);
    applyStimulus(1'b1, 3'd3, 4'hF, 32'h0);
    idleCycles(30);
    applyStimulus(1'b1, 3'd3, 4'hF, 32'h1);
    idleCycles(4);

    // Pipelined reads including the unmapped hole.
    applyStimulus(1'b0, 3'd0, 4'hF, 32'h0);
    applyStimulus(1'b0, 3'd2, 4'h0, 32'h0);
    applyStimulus(1'b0, 3'd5, 4'hF, 32'h0);
    applyStimulus(1'b0, 3'd4, 4'hF, 32'h0);
    idleCycles(2);

    // Byte-enable write.
    applyStimulus(1'b1, 3'd2, 4'hF, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 3'd2, 4'b0010, 32'hAABB_CCDD);
    applyStimulus(1'b0, 3'd2, 4'hF, 32'h0);

    // Aborted write still lands in the register.
    applyStimulus(1'b1, 3'd2, 4'hF, 32'h1234_5678);
    wb_cyc = 1'b0;
    idleCycles(1);
    wb_cyc = 1'b1;
    applyStimulus(1'b0, 3'd2, 4'hF, 32'h0);
    applyStimulus(1'b1, 3'd7, 4'hF, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 3'd2, 4'hF, 32'h0);

    // Random traffic, biased towards small values so the compare toggles.
    for (int i = 0; i < 300; i++) begin
      r_off = 3'($urandom_range(0, 7));
      r_we  = 1'($urandom_range(0, 1));
      r_sel = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      if (r_off == 3'd4)
        r_dat = $urandom_range(0, 4);
      else if ($urandom_range(0, 3) == 0)
        r_dat = $urandom;
      else
        r_dat = $urandom_range(0, 80);
      applyStimulus(r_we, r_off, r_sel, r_dat);
      idleCycles($urandom_range(0, 3));
    end

    // Bounded drain of outstanding responses.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    checkOutput("drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
